// File: rtl/bsu_pkg.sv
// rtl/bsu_pkg.sv - shared op/state types and op classification for the logic/shift unit
// BSU_ROTATE_EN decides whether op 111 iterates as a rotate or completes at once as an illegal op.
package bsu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOR = 3'b011,
    OP_SLL = 3'b100,
    OP_SRL = 3'b101,
    OP_SRA = 3'b110,
    OP_ROR = 3'b111
  } bsu_op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } bsu_state_t;

  function automatic logic is_iterative(input bsu_op_t o);
`ifdef BSU_ROTATE_EN
    return o[2];
`else
    return o[2] && (o != OP_ROR);
`endif
  endfunction

endpackage

// File: rtl/bsu_shift_step.sv
// rtl/bsu_shift_step.sv - combinational one-position shifter used once per SHIFT cycle
// The rotate path exists only when BSU_ROTATE_EN is defined.
module bsu_shift_step
  import bsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  bsu_op_t          op,
  output logic [WIDTH-1:0] next
);

  always_comb begin
    next = acc;
    case (op)
      OP_SLL:  next = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  next = {1'b0, acc[WIDTH-1:1]};
      OP_SRA:  next = {acc[WIDTH-1], acc[WIDTH-1:1]};
`ifdef BSU_ROTATE_EN
      OP_ROR:  next = {acc[0], acc[WIDTH-1:1]};
`endif
      default: next = acc;
    endcase
  end

endmodule

// File: rtl/bitwise_shift_unit.sv
// rtl/bitwise_shift_unit.sv - one-cycle bitwise ops and bit-serial shifts behind a start/done handshake
// Define BSU_ROTATE_EN to enable ROR on op 111; otherwise op 111 returns inpB in one cycle.
module bitwise_shift_unit
  import bsu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   inpA,
  input  logic [WIDTH-1:0]   inpB,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               zero
);

  bsu_state_t         state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  bsu_op_t            op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;

  bsu_op_t          op_in;
  logic [WIDTH-1:0] quick_res;
  logic [WIDTH-1:0] step_res;

  assign op_in = bsu_op_t'(op);

  // Anything finishing in one cycle that is not a logic op (shamt 0, illegal op) passes inpB through.
  always_comb begin
    quick_res = inpB;
    case (op_in)
      OP_AND:  quick_res = inpA & inpB;
      OP_OR:   quick_res = inpA | inpB;
      OP_XOR:  quick_res = inpA ^ inpB;
      OP_NOR:  quick_res = ~(inpA | inpB);
      default: quick_res = inpB;
    endcase
  end

  bsu_shift_step #(.WIDTH(WIDTH)) u_step (
    .acc  (acc_q),
    .op   (op_q),
    .next (step_res)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_iterative(op_in) && (shamt != '0)) begin
            acc_d   = inpB;
            cnt_d   = shamt;
            op_d    = op_in;
            state_d = SHIFT;
          end else begin
            result_d = quick_res;
            done_d   = 1'b1;
          end
        end
      end
      SHIFT: begin
        acc_d = step_res;
        cnt_d = cnt_q - SHAMT_W'(1);
        // Leaving at cnt==1 means cnt can never wrap below zero.
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = step_res;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= OP_AND;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_bitwise_shift_unit.sv
// tb/tb_bitwise_shift_unit.sv - directed vectors plus a per-cycle arithmetic reference model
module tb_bitwise_shift_unit;

`ifdef BSU_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] inpA = '0;
  logic [31:0] inpB = '0;
  logic [4:0]  shamt = '0;
  logic        busy, done, zero;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  bitwise_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .inpA   (inpA),
    .inpB   (inpB),
    .shamt  (shamt),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                      input logic [4:0] k);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return b << k;
      3'd5: return b >> k;
      3'd6: return 32'($signed(b) >>> k);
      default: begin
        if (!ROT || k == 0) return b;
        return (b >> k) | (b << (32 - int'(k)));
      end
    endcase
  endfunction

  function automatic int mdl_lat(input logic [2:0] o, input logic [4:0] k);
    if (o < 3'd4 || k == 0) return 0;
    if (o == 3'd7 && !ROT) return 0;
    return int'(k);
  endfunction

  // Reference model: sample inputs at the edge, settle and compare on the falling edge.
  initial begin
    logic        s_reset, s_start;
    logic [2:0]  s_op;
    logic [31:0] s_a, s_b, m_result, m_pend;
    logic [4:0]  s_k;
    bit          m_done;
    int          m_rem;
    m_result = '0; m_pend = '0; m_done = 1'b0; m_rem = 0;
    forever begin
      @(posedge clk);
      s_reset = reset; s_start = start; s_op = op; s_a = inpA; s_b = inpB; s_k = shamt;
      @(negedge clk);
      if (s_reset) begin
        m_rem = 0; m_result = '0; m_done = 1'b0;
      end else begin
        m_done = 1'b0;
        if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) begin
            m_result = m_pend;
            m_done   = 1'b1;
          end
        end else if (s_start) begin
          if (mdl_lat(s_op, s_k) == 0) begin
            m_result = mdl(s_op, s_a, s_b, s_k);
            m_done   = 1'b1;
          end else begin
            m_rem  = mdl_lat(s_op, s_k);
            m_pend = mdl(s_op, s_a, s_b, s_k);
          end
        end
      end
      if (chk_en) begin
        check("cyc_busy", busy, m_rem > 0);
        check("cyc_done", done, m_done);
        check("cyc_result", result, m_result);
        check("cyc_zero", zero, m_result == 0);
      end
    end
  end

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] k,
                     input logic [31:0] ev, input int lat, input string nm);
    int cyc;
    @(negedge clk);
    start = 1'b1; op = o; inpA = a; inpB = b; shamt = k;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check(nm, result, ev);
    check({nm, "_lat"}, cyc, lat);
    check({nm, "_zero"}, zero, ev == 0);
  endtask

  initial begin
    check("pin_sra", mdl(3'd6, '0, 32'h80000000, 5'd4), 32'hF8000000);
    check("pin_srl", mdl(3'd5, '0, 32'h80000000, 5'd4), 32'h08000000);
    check("pin_nor", mdl(3'd3, 32'hF0F0F0F0, 32'h0F0F0F0F, 5'd0), 32'h00000000);
    check("pin_lat", mdl_lat(3'd4, 5'd31), 31);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_result", result, 32'h0);
    check("rst_zero", zero, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    run(3'd2, 32'h00000000, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 0, "xor1");
    run(3'd2, 32'h55555555, 32'hFFFFFFFF, 5'd3, 32'hAAAAAAAA, 0, "xor2");
    run(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h00000000, 0, "xor3");
    run(3'd3, 32'hF0F0F0F0, 32'h0F0F0F0F, 5'd0, 32'h00000000, 0, "nor");
    run(3'd0, 32'hFF00FF00, 32'h0FF00FF0, 5'd0, 32'h0F000F00, 0, "and");
    run(3'd1, 32'h0000FFFF, 32'h00FF0000, 5'd0, 32'h00FFFFFF, 0, "or");
    run(3'd6, 32'h12345678, 32'h80000000, 5'd4, 32'hF8000000, 4, "sra4");
    run(3'd5, 32'h12345678, 32'h80000000, 5'd4, 32'h08000000, 4, "srl4");
    run(3'd6, 32'h0, 32'h40000000, 5'd2, 32'h10000000, 2, "sra_pos");
    run(3'd4, 32'h0, 32'h00000001, 5'd31, 32'h80000000, 31, "sll31");
    run(3'd4, 32'h0, 32'h00000001, 5'd0, 32'h00000001, 0, "sll0");
    run(3'd7, 32'h0, 32'h00000001, 5'd1, ROT ? 32'h80000000 : 32'h00000001, ROT ? 1 : 0, "ror1");

    // Back-to-back: second start accepted in the cycle done is high.
    @(negedge clk);
    start = 1'b1; op = 3'd1; inpA = 32'h0000FFFF; inpB = 32'h00FF0000;
    @(negedge clk);
    op = 3'd0; inpA = 32'hFF00FF00; inpB = 32'h0FF00FF0;
    @(negedge clk);
    start = 1'b0;
    check("b2b", result, 32'h0F000F00);

    // Start pulsed while shifting is ignored.
    @(negedge clk);
    start = 1'b1; op = 3'd5; inpB = 32'hF0000000; shamt = 5'd6;
    @(negedge clk);
    op = 3'd0; inpA = 32'hFFFFFFFF; inpB = 32'hFFFFFFFF; shamt = 5'd0;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("ign_result", result, 32'h03C00000);
    check("ign_busy", busy, 1'b0);

    // Reset at the third shift cycle discards the op.
    @(negedge clk);
    start = 1'b1; op = 3'd4; inpB = 32'h00000001; shamt = 5'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_mid_result", result, 32'h0);
    check("rst_mid_zero", zero, 1'b1);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    repeat (12) @(negedge clk);
    check("rst_mid_after", result, 32'h0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
